// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if
//   Request/response bundle between the three RAM requesters (instruction
//   fetch, CPU load/store, program loader) and ram_arbiter.
//
//   Ports of the bundle (master = requester side, slave = arbiter side):
//     f_valid/f_addr          fetch request
//     f_ready                 fetch accepted this cycle
//     f_rsp_valid/f_rsp_data  fetch read data, one cycle after f_ready
//     c_* / l_*               CPU / loader request (valid, we, addr, wdata),
//                             grant (ready) and read response (rsp_valid, rsp_data)
//     l_lock                  loader bus lock, present only when
//                             RAM_ARB_LOCK_EN is defined
interface ram_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              f_valid;
   logic [ADDR_W-1:0] f_addr;
   logic              f_ready;
   logic              f_rsp_valid;
   logic [DATA_W-1:0] f_rsp_data;

   logic              c_valid;
   logic              c_we;
   logic [ADDR_W-1:0] c_addr;
   logic [DATA_W-1:0] c_wdata;
   logic              c_ready;
   logic              c_rsp_valid;
   logic [DATA_W-1:0] c_rsp_data;

   logic              l_valid;
   logic              l_we;
   logic [ADDR_W-1:0] l_addr;
   logic [DATA_W-1:0] l_wdata;
   logic              l_ready;
   logic              l_rsp_valid;
   logic [DATA_W-1:0] l_rsp_data;

`ifdef RAM_ARB_LOCK_EN
   logic              l_lock;
`endif

   modport master (
`ifdef RAM_ARB_LOCK_EN
      output l_lock,
`endif
      output f_valid, f_addr,
      input  f_ready, f_rsp_valid, f_rsp_data,
      output c_valid, c_we, c_addr, c_wdata,
      input  c_ready, c_rsp_valid, c_rsp_data,
      output l_valid, l_we, l_addr, l_wdata,
      input  l_ready, l_rsp_valid, l_rsp_data
   );

   modport slave (
`ifdef RAM_ARB_LOCK_EN
      input  l_lock,
`endif
      input  f_valid, f_addr,
      output f_ready, f_rsp_valid, f_rsp_data,
      input  c_valid, c_we, c_addr, c_wdata,
      output c_ready, c_rsp_valid, c_rsp_data,
      input  l_valid, l_we, l_addr, l_wdata,
      output l_ready, l_rsp_valid, l_rsp_data
   );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares a dual-port byte RAM (port 1 read-only, port 2 read/write)
//   between instruction fetch, CPU load/store and the program loader.
//   Fetch owns port 1; CPU and loader share port 2 under round-robin.
//   Read data comes back from the RAM's registered outputs one cycle after
//   the ready cycle. Writes complete in their ready cycle, no response.
//
//   Optional feature macro: RAM_ARB_LOCK_EN
//     defined   -> loader bus lock (l_lock) with an UNLOCKED/LOCKED FSM
//     undefined -> plain round-robin every cycle, no l_lock
//
//   Ports:
//     clk          single clock
//     rst          synchronous active-high reset
//     bus          ram_arbiter_if.slave, requester handshakes and responses
//     ram_addr_1   RAM port 1 address (follows f_addr)
//     ram_addr_2   RAM port 2 address (granted requester, else held)
//     ram_wdata    RAM port 2 write data
//     ram_we       RAM port 2 write enable
//     ram_rdata_1  RAM port 1 registered read data
//     ram_rdata_2  RAM port 2 registered read data
module ram_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   ram_arbiter_if.slave      bus,
   output logic [ADDR_W-1:0] ram_addr_1,
   output logic [ADDR_W-1:0] ram_addr_2,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_rdata_1,
   input  logic [DATA_W-1:0] ram_rdata_2
);

   logic              last_l;
   logic              p1_pend;
   logic              p2_pend_c;
   logic              p2_pend_l;
   logic [ADDR_W-1:0] addr_2_hold;

   logic              c_req;
   logic              l_req;
   logic              grant_c;
   logic              grant_l;
   logic              granted;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_we;
   logic              stall;
   logic              f_accept;
   logic              locked;

`ifdef RAM_ARB_LOCK_EN
   typedef enum logic {UNLOCKED, LOCKED} arb_state_t;
   arb_state_t state;

   // The lock releases combinationally: the first cycle with l_lock low
   // already lets the CPU compete again.
   assign locked = (state == LOCKED) && bus.l_lock;

   // Lock FSM: entered when the loader wins port 2 while asserting l_lock,
   // left as soon as l_lock drops.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= UNLOCKED;
      end else begin
         case (state)
            UNLOCKED: if (grant_l && bus.l_lock) state <= LOCKED;
            LOCKED:   if (!bus.l_lock)           state <= UNLOCKED;
            default:  state <= UNLOCKED;
         endcase
      end
   end
`else
   assign locked = 1'b0;
`endif

   // Port 2 arbitration. On a tie the requester not granted last wins.
   // A port-2 write to the address fetch is reading would return stale
   // port-1 data, so fetch is held off for that cycle. Everything is
   // gated by rst so outputs show reset values during the reset cycle.
   always_comb begin
      c_req     = bus.c_valid && !locked && !rst;
      l_req     = bus.l_valid && !rst;
      grant_c   = c_req && (!l_req || last_l);
      grant_l   = l_req && !grant_c;
      granted   = grant_c || grant_l;
      sel_addr  = grant_l ? bus.l_addr  : bus.c_addr;
      sel_wdata = grant_l ? bus.l_wdata : bus.c_wdata;
      sel_we    = (grant_c && bus.c_we) || (grant_l && bus.l_we);
      stall     = sel_we && (bus.f_addr == sel_addr);
      f_accept  = bus.f_valid && !stall && !rst;
   end

   assign ram_addr_1 = rst ? '0 : bus.f_addr;
   assign ram_addr_2 = rst ? '0 : (granted ? sel_addr : addr_2_hold);
   assign ram_wdata  = granted ? sel_wdata : '0;
   assign ram_we     = sel_we;

   assign bus.f_ready = f_accept;
   assign bus.c_ready = grant_c;
   assign bus.l_ready = grant_l;

   // Response data is forced to zero whenever its valid is low.
   assign bus.f_rsp_valid = p1_pend && !rst;
   assign bus.f_rsp_data  = (p1_pend && !rst) ? ram_rdata_1 : '0;
   assign bus.c_rsp_valid = p2_pend_c && !rst;
   assign bus.c_rsp_data  = (p2_pend_c && !rst) ? ram_rdata_2 : '0;
   assign bus.l_rsp_valid = p2_pend_l && !rst;
   assign bus.l_rsp_data  = (p2_pend_l && !rst) ? ram_rdata_2 : '0;

   // Round-robin history, held port-2 address and read-response tags.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_l      <= 1'b1;
         addr_2_hold <= '0;
         p1_pend     <= 1'b0;
         p2_pend_c   <= 1'b0;
         p2_pend_l   <= 1'b0;
      end else begin
         if (grant_c) begin
            last_l <= 1'b0;
         end else if (grant_l) begin
            last_l <= 1'b1;
         end
         if (granted) begin
            addr_2_hold <= sel_addr;
         end
         p1_pend   <= f_accept;
         p2_pend_c <= grant_c && !bus.c_we;
         p2_pend_l <= grant_l && !bus.l_we;
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
//   Self-checking bench for ram_arbiter. Models the dual-port RAM
//   (registered read, read-before-write), drives scenarios through the
//   interface, and checks read responses against a scoreboard of expected
//   data and due cycles. Lock scenario only when RAM_ARB_LOCK_EN is defined.
module tb_ram_arbiter;
   localparam int AW = 8;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] ram_addr_1;
   logic [AW-1:0] ram_addr_2;
   logic [DW-1:0] ram_wdata;
   logic          ram_we;
   logic [DW-1:0] ram_rdata_1;
   logic [DW-1:0] ram_rdata_2;
   logic [DW-1:0] mem [0:255];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic [DW-1:0] data;
      int            due;
   } exp_t;

   exp_t qf[$];
   exp_t qc[$];
   exp_t ql[$];

   ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

   ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus),
      .ram_addr_1(ram_addr_1),
      .ram_addr_2(ram_addr_2),
      .ram_wdata(ram_wdata),
      .ram_we(ram_we),
      .ram_rdata_1(ram_rdata_1),
      .ram_rdata_2(ram_rdata_2)
   );

   always #5 clk = ~clk;

   // RAM model: registered reads return the pre-write contents.
   always @(posedge clk) begin
      cyc++;
      ram_rdata_1 <= mem[ram_addr_1];
      ram_rdata_2 <= mem[ram_addr_2];
      if (ram_we === 1'b1) mem[ram_addr_2] <= ram_wdata;
   end

   // Initial RAM contents.
   function automatic logic [7:0] pat(input int a);
      if (a == 16) return 8'hA5;
      return 8'(a) ^ 8'h3C;
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.f_valid = 1'b0; bus.f_addr = '0;
      bus.c_valid = 1'b0; bus.c_we = 1'b0; bus.c_addr = '0; bus.c_wdata = '0;
      bus.l_valid = 1'b0; bus.l_we = 1'b0; bus.l_addr = '0; bus.l_wdata = '0;
`ifdef RAM_ARB_LOCK_EN
      bus.l_lock = 1'b0;
`endif
   endtask

   // Response monitor: pops the scoreboard on every response and flags
   // unexpected, late, missing or non-zero idle responses.
   always @(negedge clk) begin
      exp_t e;
      if (bus.f_rsp_valid === 1'b1) begin
         checks++;
         if (qf.size() == 0) begin
            errors++; $display("[TB] FAIL f_rsp_unexpected got valid=1 data=%h want valid=0", bus.f_rsp_data);
         end else begin
            e = qf.pop_front();
            if (bus.f_rsp_data !== e.data || cyc != e.due) begin
               errors++; $display("[TB] FAIL f_rsp got %h at cycle %0d want %h at cycle %0d", bus.f_rsp_data, cyc, e.data, e.due);
            end
         end
      end else begin
         checks++;
         if (bus.f_rsp_data !== '0) begin
            errors++; $display("[TB] FAIL f_rsp_data_idle got %h want 00", bus.f_rsp_data);
         end
         if (qf.size() > 0 && qf[0].due <= cyc) begin
            e = qf.pop_front();
            checks++; errors++; $display("[TB] FAIL f_rsp_missing got valid=%b want data %h at cycle %0d", bus.f_rsp_valid, e.data, e.due);
         end
      end

      if (bus.c_rsp_valid === 1'b1) begin
         checks++;
         if (qc.size() == 0) begin
            errors++; $display("[TB] FAIL c_rsp_unexpected got valid=1 data=%h want valid=0", bus.c_rsp_data);
         end else begin
            e = qc.pop_front();
            if (bus.c_rsp_data !== e.data || cyc != e.due) begin
               errors++; $display("[TB] FAIL c_rsp got %h at cycle %0d want %h at cycle %0d", bus.c_rsp_data, cyc, e.data, e.due);
            end
         end
      end else begin
         checks++;
         if (bus.c_rsp_data !== '0) begin
            errors++; $display("[TB] FAIL c_rsp_data_idle got %h want 00", bus.c_rsp_data);
         end
         if (qc.size() > 0 && qc[0].due <= cyc) begin
            e = qc.pop_front();
            checks++; errors++; $display("[TB] FAIL c_rsp_missing got valid=%b want data %h at cycle %0d", bus.c_rsp_valid, e.data, e.due);
         end
      end

      if (bus.l_rsp_valid === 1'b1) begin
         checks++;
         if (ql.size() == 0) begin
            errors++; $display("[TB] FAIL l_rsp_unexpected got valid=1 data=%h want valid=0", bus.l_rsp_data);
         end else begin
            e = ql.pop_front();
            if (bus.l_rsp_data !== e.data || cyc != e.due) begin
               errors++; $display("[TB] FAIL l_rsp got %h at cycle %0d want %h at cycle %0d", bus.l_rsp_data, cyc, e.data, e.due);
            end
         end
      end else begin
         checks++;
         if (bus.l_rsp_data !== '0) begin
            errors++; $display("[TB] FAIL l_rsp_data_idle got %h want 00", bus.l_rsp_data);
         end
         if (ql.size() > 0 && ql[0].due <= cyc) begin
            e = ql.pop_front();
            checks++; errors++; $display("[TB] FAIL l_rsp_missing got valid=%b want data %h at cycle %0d", bus.l_rsp_valid, e.data, e.due);
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1;
      bus.f_valid = 1'b1; bus.f_addr = 8'h33;
      bus.c_valid = 1'b1; bus.c_addr = 8'h44;
      bus.l_valid = 1'b1; bus.l_addr = 8'h55; bus.l_we = 1'b1;
      sample();
      checks++;
      if (bus.f_ready !== 1'b0 || bus.c_ready !== 1'b0 || bus.l_ready !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_ready got f=%b c=%b l=%b want 0 0 0", bus.f_ready, bus.c_ready, bus.l_ready);
      end
      checks++;
      if (ram_we !== 1'b0 || ram_addr_1 !== 8'h00 || ram_addr_2 !== 8'h00) begin
         errors++; $display("[TB] FAIL reset_ram got we=%b a1=%h a2=%h want 0 00 00", ram_we, ram_addr_1, ram_addr_2);
      end
      next_cycle();
      rst = 1'b0;
      idle_inputs();
      sample();
      checks++;
      if (ram_we !== 1'b0 || ram_addr_2 !== 8'h00) begin
         errors++; $display("[TB] FAIL reset_idle got we=%b a2=%h want 0 00", ram_we, ram_addr_2);
      end
      next_cycle();
   endtask

   task automatic test_fetch();
      bus.f_valid = 1'b1; bus.f_addr = 8'h10;
      sample();
      checks++;
      if (bus.f_ready !== 1'b1 || ram_addr_1 !== 8'h10) begin
         errors++; $display("[TB] FAIL fetch_accept got ready=%b a1=%h want 1 10", bus.f_ready, ram_addr_1);
      end
      qf.push_back('{data: 8'hA5, due: cyc + 1});
      next_cycle();
      idle_inputs();
      next_cycle();
   endtask

   task automatic test_round_robin();
      logic exp_c;
      bus.c_valid = 1'b1; bus.c_we = 1'b0; bus.c_addr = 8'h20;
      bus.l_valid = 1'b1; bus.l_we = 1'b0; bus.l_addr = 8'h30;
      for (int i = 0; i < 6; i++) begin
         sample();
         exp_c = (i % 2 == 0);
         checks++;
         if (bus.c_ready !== exp_c || bus.l_ready !== !exp_c) begin
            errors++; $display("[TB] FAIL rr_grant_%0d got c=%b l=%b want c=%b l=%b", i, bus.c_ready, bus.l_ready, exp_c, !exp_c);
         end
         checks++;
         if (ram_addr_2 !== (exp_c ? 8'h20 : 8'h30) || ram_we !== 1'b0) begin
            errors++; $display("[TB] FAIL rr_addr_%0d got a2=%h we=%b want %h 0", i, ram_addr_2, ram_we, exp_c ? 8'h20 : 8'h30);
         end
         if (exp_c) qc.push_back('{data: pat(8'h20), due: cyc + 1});
         else       ql.push_back('{data: pat(8'h30), due: cyc + 1});
         next_cycle();
      end
      idle_inputs();
      next_cycle();
   endtask

   task automatic test_collision();
      bus.l_valid = 1'b1; bus.l_we = 1'b1; bus.l_addr = 8'h40; bus.l_wdata = 8'h5A;
      bus.f_valid = 1'b1; bus.f_addr = 8'h40;
      sample();
      checks++;
      if (bus.l_ready !== 1'b1 || ram_we !== 1'b1 || bus.f_ready !== 1'b0) begin
         errors++; $display("[TB] FAIL collision_stall got l_ready=%b we=%b f_ready=%b want 1 1 0", bus.l_ready, ram_we, bus.f_ready);
      end
      next_cycle();
      bus.l_valid = 1'b0; bus.l_we = 1'b0;
      sample();
      checks++;
      if (bus.f_ready !== 1'b1) begin
         errors++; $display("[TB] FAIL collision_retry got f_ready=%b want 1", bus.f_ready);
      end
      qf.push_back('{data: 8'h5A, due: cyc + 1});
      next_cycle();
      idle_inputs();
      next_cycle();
   endtask

   task automatic test_write_read();
      bus.c_valid = 1'b1; bus.c_we = 1'b1; bus.c_addr = 8'h50; bus.c_wdata = 8'h11;
      bus.f_valid = 1'b1; bus.f_addr = 8'h51;
      sample();
      checks++;
      if (bus.c_ready !== 1'b1 || bus.f_ready !== 1'b1 || ram_we !== 1'b1 || ram_wdata !== 8'h11) begin
         errors++; $display("[TB] FAIL write_parallel got c=%b f=%b we=%b wd=%h want 1 1 1 11", bus.c_ready, bus.f_ready, ram_we, ram_wdata);
      end
      qf.push_back('{data: pat(8'h51), due: cyc + 1});
      next_cycle();
      bus.f_valid = 1'b0;
      bus.c_we = 1'b0;
      sample();
      checks++;
      if (bus.c_ready !== 1'b1 || ram_we !== 1'b0) begin
         errors++; $display("[TB] FAIL write_readback got c_ready=%b we=%b want 1 0", bus.c_ready, ram_we);
      end
      qc.push_back('{data: 8'h11, due: cyc + 1});
      next_cycle();
      idle_inputs();
      sample();
      checks++;
      if (ram_we !== 1'b0 || ram_addr_2 !== 8'h50) begin
         errors++; $display("[TB] FAIL idle_hold got we=%b a2=%h want 0 50", ram_we, ram_addr_2);
      end
      next_cycle();
   endtask

`ifdef RAM_ARB_LOCK_EN
   task automatic test_lock();
      bus.c_valid = 1'b1; bus.c_we = 1'b0; bus.c_addr = 8'h20;
      for (int i = 0; i < 4; i++) begin
         bus.l_valid = 1'b1; bus.l_we = 1'b1; bus.l_lock = 1'b1;
         bus.l_addr = 8'h60 + 8'(i); bus.l_wdata = 8'h70 + 8'(i);
         sample();
         checks++;
         if (bus.c_ready !== 1'b0 || bus.l_ready !== 1'b1 || ram_we !== 1'b1) begin
            errors++; $display("[TB] FAIL lock_hold_%0d got c=%b l=%b we=%b want 0 1 1", i, bus.c_ready, bus.l_ready, ram_we);
         end
         next_cycle();
      end
      bus.l_valid = 1'b0; bus.l_we = 1'b0; bus.l_lock = 1'b0;
      sample();
      checks++;
      if (bus.c_ready !== 1'b1) begin
         errors++; $display("[TB] FAIL lock_release got c_ready=%b want 1", bus.c_ready);
      end
      qc.push_back('{data: pat(8'h20), due: cyc + 1});
      next_cycle();
      bus.c_valid = 1'b0;
      bus.l_valid = 1'b1; bus.l_addr = 8'h62;
      sample();
      checks++;
      if (bus.l_ready !== 1'b1) begin
         errors++; $display("[TB] FAIL lock_readback got l_ready=%b want 1", bus.l_ready);
      end
      ql.push_back('{data: 8'h72, due: cyc + 1});
      next_cycle();
      idle_inputs();
      next_cycle();
   endtask
`endif

   task automatic test_reset_mid();
      bus.c_valid = 1'b1; bus.c_we = 1'b0; bus.c_addr = 8'h20;
      sample();
      checks++;
      if (bus.c_ready !== 1'b1) begin
         errors++; $display("[TB] FAIL mid_accept got c_ready=%b want 1", bus.c_ready);
      end
      next_cycle();
      rst = 1'b1;
      bus.l_valid = 1'b1; bus.l_addr = 8'h30;
      bus.f_valid = 1'b1; bus.f_addr = 8'h22;
      sample();
      checks++;
      if (bus.c_rsp_valid !== 1'b0 || bus.c_rsp_data !== 8'h00) begin
         errors++; $display("[TB] FAIL mid_no_rsp got valid=%b data=%h want 0 00", bus.c_rsp_valid, bus.c_rsp_data);
      end
      checks++;
      if (bus.c_ready !== 1'b0 || bus.l_ready !== 1'b0 || bus.f_ready !== 1'b0 || ram_addr_1 !== 8'h00 || ram_addr_2 !== 8'h00 || ram_we !== 1'b0) begin
         errors++; $display("[TB] FAIL mid_reset_out got c=%b l=%b f=%b a1=%h a2=%h we=%b want 0 0 0 00 00 0", bus.c_ready, bus.l_ready, bus.f_ready, ram_addr_1, ram_addr_2, ram_we);
      end
      next_cycle();
      rst = 1'b0;
      bus.f_valid = 1'b0;
      sample();
      checks++;
      if (bus.c_rsp_valid !== 1'b0 || bus.c_ready !== 1'b1 || bus.l_ready !== 1'b0) begin
         errors++; $display("[TB] FAIL mid_after got rsp=%b c=%b l=%b want 0 1 0", bus.c_rsp_valid, bus.c_ready, bus.l_ready);
      end
      qc.push_back('{data: pat(8'h20), due: cyc + 1});
      next_cycle();
      idle_inputs();
      next_cycle();
      next_cycle();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = pat(i);
      rst = 1'b1;
      idle_inputs();
      next_cycle();
      test_reset();
      test_fetch();
      test_round_robin();
      test_collision();
      test_write_read();
`ifdef RAM_ARB_LOCK_EN
      test_lock();
`endif
      test_reset_mid();
      checks++;
      if (qf.size() + qc.size() + ql.size() != 0) begin
         errors++; $display("[TB] FAIL drain got %0d outstanding responses want 0", qf.size() + qc.size() + ql.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout got no end of test want finish before 200000");
      $fatal(1, "[TB] timeout");
   end

endmodule
